// File: rtl/grn_ctrl_pkg.sv
// Shared types and default sizes for the GRN attractor sequencer.
// Provides the FSM state encoding and default parameter values.
package grn_ctrl_pkg;

    localparam int NODES_DEF     = 8;
    localparam int STEP_W_DEF    = 16;
    localparam int MAX_STEPS_DEF = 1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STEP,
        ST_CHECK,
        ST_OUT,
        ST_NEXT
    } state_t;

endpackage

// File: rtl/grn_init_gen.sv
// Initial-state generator: holds the current and last initial state of a sweep.
// Ports: clk, rst, load (capture cfg), advance (cur+1), cfg_first/cfg_last in;
//        cur, empty (cfg_first > cfg_last), at_last (cur == last) out.
module grn_init_gen
    import grn_ctrl_pkg::*;
#(
    parameter int NODES = NODES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [NODES-1:0] cfg_first,
    input  logic [NODES-1:0] cfg_last,
    output logic [NODES-1:0] cur,
    output logic             empty,
    output logic             at_last
);

    logic [NODES-1:0] last;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= '0;
            last <= '0;
        end else if (load) begin
            cur  <= cfg_first;
            last <= cfg_last;
        end else if (advance) begin
            cur  <= cur + 1'b1;
        end
    end

    // Evaluated on the live cfg inputs, so it is valid in the capture cycle.
    assign empty   = cfg_first > cfg_last;
    // Tested before any increment, so last = all-ones ends the sweep cleanly.
    assign at_last = cur == last;

endmodule

// File: rtl/grn_attractor_ctrl.sv
// Sweeps initial states through a dual-stream GRN node bank using Floyd
// tortoise/hare stepping and reports one result record per initial state.
// Ports: clk, rst, start, cfg_first, cfg_last, st_s0, st_s1, res_ready in;
//        reset_nos, start_s0, start_s1, init_state, res_valid, res_init,
//        res_steps, res_timeout, busy, done out.
module grn_attractor_ctrl
    import grn_ctrl_pkg::*;
#(
    parameter int NODES     = NODES_DEF,
    parameter int STEP_W    = STEP_W_DEF,
    parameter int MAX_STEPS = MAX_STEPS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NODES-1:0]  cfg_first,
    input  logic [NODES-1:0]  cfg_last,
    input  logic [NODES-1:0]  st_s0,
    input  logic [NODES-1:0]  st_s1,
    output logic              reset_nos,
    output logic              start_s0,
    output logic              start_s1,
    output logic [NODES-1:0]  init_state,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [NODES-1:0]  res_init,
    output logic [STEP_W-1:0] res_steps,
    output logic              res_timeout,
    output logic              busy,
    output logic              done
);

    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);

    state_t            state;
    state_t            nxt;
    logic [STEP_W-1:0] steps;
    logic              timeout_q;
    logic              done_q;

    logic              load;
    logic              advance;
    logic [NODES-1:0]  cur;
    logic              empty;
    logic              at_last;

    logic              hit;
    logic              lim;

    grn_init_gen #(
        .NODES(NODES)
    ) u_init (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .advance  (advance),
        .cfg_first(cfg_first),
        .cfg_last (cfg_last),
        .cur      (cur),
        .empty    (empty),
        .at_last  (at_last)
    );

    // At odd step counts the slow stream may equal the fast one trivially,
    // so a match only counts on even counts.
    assign hit = ~steps[0] && (st_s0 == st_s1);
    assign lim = ~hit && (steps == STEP_MAX);

    always_comb begin
        nxt       = state;
        load      = 1'b0;
        advance   = 1'b0;
        reset_nos = 1'b0;
        start_s0  = 1'b0;
        start_s1  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    nxt  = empty ? ST_IDLE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                reset_nos = 1'b1;
                nxt       = ST_STEP;
            end
            ST_STEP: begin
                start_s0 = 1'b1;
                start_s1 = 1'b1;
                nxt      = ST_CHECK;
            end
            ST_CHECK: begin
                unique case (1'b1)
                    hit:     nxt = ST_OUT;
                    lim:     nxt = ST_OUT;
                    default: nxt = ST_STEP;
                endcase
            end
            ST_OUT: begin
                if (res_ready) begin
                    nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (at_last) begin
                    nxt = ST_IDLE;
                end else begin
                    advance = 1'b1;
                    nxt     = ST_LOAD;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            steps     <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= nxt;
            // Empty-range sweeps finish straight from IDLE.
            done_q <= (state == ST_IDLE) && start && empty;
            if (state == ST_LOAD) begin
                steps <= '0;
            end
            if (state == ST_STEP) begin
                steps <= steps + 1'b1;
            end
            if (state == ST_CHECK) begin
                timeout_q <= lim;
            end
        end
    end

    assign init_state  = (state == ST_LOAD) ? cur : '0;
    assign res_valid   = state == ST_OUT;
    assign res_init    = res_valid ? cur : '0;
    assign res_steps   = res_valid ? steps : '0;
    assign res_timeout = res_valid && timeout_q;
    assign busy        = state != ST_IDLE;
    assign done        = done_q || ((state == ST_NEXT) && at_last);

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Scoreboard bench for grn_attractor_ctrl with a behavioural node bank.
// Expected results come from iterating the node map directly.
module tb_grn_attractor_ctrl;

    localparam int NODES = 8;
    localparam int SW    = 16;
    localparam int MAXS  = 16;

    typedef struct {
        logic [NODES-1:0] init;
        logic [SW-1:0]    steps;
        logic             to;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [NODES-1:0] cfg_first;
    logic [NODES-1:0] cfg_last;
    logic [NODES-1:0] st_s0;
    logic [NODES-1:0] st_s1;
    logic             reset_nos;
    logic             start_s0;
    logic             start_s1;
    logic [NODES-1:0] init_state;
    logic             res_valid;
    logic             res_ready;
    logic [NODES-1:0] res_init;
    logic [SW-1:0]    res_steps;
    logic             res_timeout;
    logic             busy;
    logic             done;

    logic [NODES-1:0] tbl [256];
    logic             ph;
    exp_t             exp_q[$];
    int               n_chk = 0;
    int               n_pass = 0;
    int               n_res = 0;
    int               last_hs = 0;
    int               cyc = 0;
    int               stall_cnt = 0;
    bit               rand_rdy = 0;

    grn_attractor_ctrl #(
        .NODES(NODES), .STEP_W(SW), .MAX_STEPS(MAXS)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_first(cfg_first), .cfg_last(cfg_last),
        .st_s0(st_s0), .st_s1(st_s1),
        .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1),
        .init_state(init_state),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_init(res_init), .res_steps(res_steps),
        .res_timeout(res_timeout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Node bank: s1 follows every step, s0 every other step.
    always @(posedge clk) begin
        if (rst) begin
            st_s0 <= '0;
            st_s1 <= '0;
            ph    <= 1'b0;
        end else if (reset_nos) begin
            st_s0 <= init_state;
            st_s1 <= init_state;
            ph    <= 1'b0;
        end else begin
            if (start_s1) st_s1 <= tbl[st_s1];
            if (start_s0) begin
                if (!ph) st_s0 <= tbl[st_s0];
                ph <= ~ph;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    // Reference: after k steps fast = f^k(x), slow = f^ceil(k/2)(x).
    function automatic exp_t model(input logic [NODES-1:0] x);
        exp_t e;
        logic [NODES-1:0] a;
        logic [NODES-1:0] b;
        a = x;
        b = x;
        e.init  = x;
        e.steps = SW'(MAXS);
        e.to    = 1'b1;
        for (int k = 1; k <= MAXS; k++) begin
            b = tbl[b];
            if (k % 2 == 1) a = tbl[a];
            if (k % 2 == 0 && a == b) begin
                e.steps = SW'(k);
                e.to    = 1'b0;
                return e;
            end
        end
        return e;
    endfunction

    // Ready driver: optional forced stall on the next result, else random or 1.
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0 && res_valid) begin
                res_ready = 1'b0;
                stall_cnt--;
            end else if (rand_rdy) begin
                res_ready = ($urandom % 3) != 0;
            end else begin
                res_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each handshake and watches stalls.
    initial begin
        exp_t e;
        logic [NODES-1:0] h_init;
        logic [SW-1:0]    h_steps;
        logic             h_to;
        bit               held = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
            end else if (res_valid) begin
                chk("nodes_idle_in_out", {reset_nos, start_s0, start_s1}, 0);
                if (held) begin
                    chk("stall_init", res_init, h_init);
                    chk("stall_steps", res_steps, h_steps);
                    chk("stall_to", res_timeout, h_to);
                end
                if (res_ready) begin
                    held = 0;
                    n_res++;
                    last_hs = cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_init", res_init, e.init);
                        chk("res_steps", res_steps, e.steps);
                        chk("res_timeout", res_timeout, e.to);
                    end
                end else begin
                    held    = 1;
                    h_init  = res_init;
                    h_steps = res_steps;
                    h_to    = res_timeout;
                end
            end else begin
                held = 0;
            end
        end
    end

    task automatic sweep(input logic [NODES-1:0] f,
                         input logic [NODES-1:0] l, input bit poke);
        int got;
        int dcyc;
        int sc;
        int base;
        base = n_res;
        for (int x = int'(f); x <= int'(l); x++) exp_q.push_back(model(NODES'(x)));
        cfg_first = f;
        cfg_last  = l;
        @(negedge clk);
        start = 1'b1;
        sc    = cyc;
        got   = 0;
        dcyc  = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (poke && i == 12) begin
                start     = 1'b1;
                cfg_first = 8'h00;
                cfg_last  = 8'hff;
            end
            if (poke && i == 13) start = 1'b0;
            if (done) begin
                got  = 1;
                dcyc = cyc;
                break;
            end
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        if (got != 0) begin
            if (f > l) begin
                chk("done_lat_empty", dcyc - sc, 1);
                chk("no_result_empty", n_res - base, 0);
            end else begin
                chk("done_after_hs", dcyc - last_hs, 1);
                chk("result_count", n_res - base, int'(l) - int'(f) + 1);
            end
        end
        repeat (3) @(negedge clk);
        chk("idle_after_done", {busy, res_valid}, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int found;
        logic [NODES-1:0] f;
        logic [NODES-1:0] l;
        rst       = 1'b1;
        start     = 1'b0;
        cfg_first = '0;
        cfg_last  = '0;
        for (int i = 0; i < 256; i++) tbl[i] = NODES'(i);
        repeat (3) @(negedge clk);
        chk("reset_ctl", {reset_nos, start_s0, start_s1, busy, done}, 0);
        chk("reset_res", {res_valid, res_timeout, res_init, res_steps}, 0);
        chk("reset_init", init_state, 0);
        rst = 1'b0;

        // Identity map: detection at the first even step.
        sweep(8'd3, 8'd3, 0);

        // Increment map never meets within the step limit.
        for (int i = 0; i < 256; i++) tbl[i] = NODES'(i + 1);
        sweep(8'd0, 8'd0, 0);

        // Top of range with a long stall on the first result.
        for (int i = 0; i < 256; i++) tbl[i] = NODES'($urandom);
        stall_cnt = 10;
        sweep(8'hFE, 8'hFF, 0);
        chk("stall_consumed", stall_cnt, 0);

        // Empty range.
        sweep(8'd5, 8'd2, 0);

        // Reset during the first step of the second initial state.
        for (int i = 0; i < 256; i++) tbl[i] = NODES'(i + 1);
        for (int x = 10; x <= 12; x++) exp_q.push_back(model(NODES'(x)));
        found     = n_res;
        cfg_first = 8'd10;
        cfg_last  = 8'd12;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (n_res == found + 1 && start_s0) begin
                found = -1;
                break;
            end
        end
        chk("reached_2nd_step", found, -1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_nodes", {reset_nos, start_s0, start_s1}, 0);
        exp_q.delete();
        rst = 1'b0;
        sweep(8'd10, 8'd12, 0);

        // Start pulsed mid-sweep with different cfg is ignored.
        sweep(8'd20, 8'd22, 1);

        // Random maps, ranges and backpressure.
        rand_rdy = 1;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 256; i++) tbl[i] = NODES'($urandom);
            f = NODES'($urandom);
            l = (int'(f) + 3 > 255) ? 8'hFF : NODES'(int'(f) + $urandom_range(0, 3));
            sweep(f, l, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
